mult_acc: RTL and testbench
===========================

Name: mult_acc

Overview:
- Downstream consumer of the pipelined `mult` block. Takes its `rdy`/`result` stream and sums every K consecutive products into one group sum.
- Delivers group sums through a 2-entry output buffer with a valid/ready handshake.
- `mult` has no backpressure, so a sum that cannot be buffered is dropped and flagged by a sticky overflow bit.

Parameters:
- N, 8, width of multiplicand mult1 (must match `mult`)
- M, 4, width of multiplier mult2 (must match `mult`)
- K, 4, products per group; K >= 2
- W (localparam), N+M+$clog2(K), width of group sum; cannot overflow

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_vld  in  1  product valid; driven by `mult` rdy
- in_data  in  N+M  product; driven by `mult` result
- clr  in  1  synchronous clear of accumulator, buffer and flag
- out_vld  out  1  out_sum holds a valid group sum
- out_rdy  in  1  consumer accepts out_sum when out_vld && out_rdy
- out_sum  out  W  oldest buffered group sum
- grp_idx  out  log2(K) (min 1)  number of products already accumulated in the current group
- ovf  out  1  sticky: a completed sum was dropped

Behaviour:
- Reset (async, rst_n=0):
  - acc=0, cnt=0, buffer EMPTY.
  - out_vld=0, out_sum=0, grp_idx=0, ovf=0.
- Accumulate, on an in_vld cycle:
  - cnt<K-1: acc <= acc + zero-extended in_data; cnt <= cnt+1.
  - cnt==K-1: sum = acc + in_data is pushed to the buffer; acc <= 0; cnt <= 0.
- in_vld=0: acc and cnt hold. Gaps between products inside a group are legal.
- Latency: the sum is on out_sum with out_vld=1 in the cycle after the clock edge that sampled the K-th product.
- Buffer: 2 entries, FIFO order. Occupancy FSM:
  - EMPTY: push -> ONE.
  - ONE: push without pop -> FULL; pop without push -> EMPTY; push and pop -> ONE, new entry becomes head.
  - FULL: pop without push -> ONE; push and pop -> FULL.
  - FULL, push without pop: the new sum is dropped, ovf <= 1, FSM stays FULL, existing entries untouched.
- Handshake:
  - pop = out_vld && out_rdy.
  - out_vld=1 exactly when not EMPTY.
  - out_sum is stable while out_vld && !out_rdy.
  - out_rdy is ignored when EMPTY.
- clr (synchronous, highest priority):
  - acc, cnt, buffer and ovf all go to 0 / EMPTY at the next edge.
  - A coincident in_vld product is discarded.
  - A coincident pop does not complete.
- ovf: cleared only by rst_n or clr.
- Width: all arithmetic is unsigned at width W. The maximum (2^N-1)(2^M-1)K fits W; no wrap.
- Reset mid-group: the partial sum is lost; the next product starts a fresh group at cnt=0.

Decomposition:
- Package mult_pkg holds:
  - default N, M, K
  - function sum_width(N,M,K)
  - enum occ_t {EMPTY, ONE, FULL}
- Sub-module mult_acc_buf2: 2-entry valid/ready buffer, parameterised on W, exposing push, full and pop/empty.
- mult_acc keeps the accumulator, group counter, clr and ovf logic.

Test Plan:
- Stream products 125, 160, 40, 105 back-to-back (from 25*5, 16*10, 10*4, 15*7), out_rdy=1 -> one out_sum=430, out_vld high for 1 cycle, one cycle after the 4th product; grp_idx steps 0,1,2,3,0.
- mult1=16..19 times mult2=7 with idle in_vld cycles between products -> out_sum=490; idle cycles do not change acc.
- All products 3825 (255*15), out_rdy=1 -> out_sum=15300, no truncation (W=14).
- out_rdy=0 for 3 full groups of 430 -> first two sums buffered (FULL), third dropped, ovf=1; then out_rdy=1 -> 430, 430 popped in order, then out_vld=0, ovf stays 1.
- Buffer FULL, push and pop in the same cycle -> stays FULL, no drop, ovf=0, order preserved.
- clr asserted after 2 products, coincident with a 3rd in_vld -> acc=0, grp_idx=0, ovf=0, buffer EMPTY; then 4 products of 1 -> out_sum=4.
- rst_n pulsed low mid-group, asynchronously -> all outputs 0 immediately; next 4 products form a fresh group.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared defaults and types for the multiplier accumulator slice.
package mult_pkg;

    localparam int N_DEF = 8;
    localparam int M_DEF = 4;
    localparam int K_DEF = 4;

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        FULL
    } occ_t;

    function automatic int sum_width(input int n, input int m, input int k);
        return n + m + $clog2(k);
    endfunction

endpackage

// File: rtl/mult_acc_buf2.sv
// Two-entry FIFO with valid/ready output; a push into a full buffer
// without a coincident pop is ignored and reported by the caller.
module mult_acc_buf2
    import mult_pkg::*;
#(
    parameter int W = 14
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         rdy_i,
    output logic         vld_o,
    output logic [W-1:0] data_o,
    output logic         full_o,
    output logic         pop_o
);

    occ_t         state_q, state_d;
    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        pop_o   = (state_q != EMPTY) && rdy_i && !clr_i;
        if (clr_i) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (push_i) begin
                        head_d  = data_i;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    case ({push_i, pop_o})
                        2'b10: begin
                            tail_d  = data_i;
                            state_d = FULL;
                        end
                        2'b01: state_d = EMPTY;
                        2'b11: head_d = data_i;
                        default: ;
                    endcase
                end
                FULL: begin
                    // full push without pop drops the new sum
                    if (pop_o) begin
                        head_d = tail_q;
                        if (push_i) tail_d = data_i;
                        else state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    assign vld_o  = (state_q != EMPTY);
    assign data_o = vld_o ? head_q : '0;
    assign full_o = (state_q == FULL);

endmodule

// File: rtl/mult_acc.sv
// Sums every K products from the mult stream and queues each group
// sum in a two-entry buffer; sums that find it full are dropped.
module mult_acc
    import mult_pkg::*;
#(
    parameter int   N  = N_DEF,
    parameter int   M  = M_DEF,
    parameter int   K  = K_DEF,
    localparam int  W  = sum_width(N, M, K),
    localparam int  CW = (K > 1) ? $clog2(K) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_vld,
    input  logic [N+M-1:0] in_data,
    input  logic          clr,
    output logic          out_vld,
    input  logic          out_rdy,
    output logic [W-1:0]  out_sum,
    output logic [CW-1:0] grp_idx,
    output logic          ovf
);

    localparam logic [CW-1:0] LAST = CW'(K - 1);

    logic [W-1:0]  acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic [W-1:0]  sum;
    logic          last;
    logic          push;
    logic          full;
    logic          pop;

    assign last = (cnt_q == LAST);
    assign sum  = acc_q + W'(in_data);
    assign push = in_vld && last && !clr;

    mult_acc_buf2 #(
        .W (W)
    ) u_buf (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (clr),
        .push_i (push),
        .data_i (sum),
        .rdy_i  (out_rdy),
        .vld_o  (out_vld),
        .data_o (out_sum),
        .full_o (full),
        .pop_o  (pop)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clr) begin
            acc_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (in_vld) begin
            if (last) begin
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + 1'b1;
            end
            if (push && full && !pop) ovf_d = 1'b1;
        end
    end

    assign grp_idx = cnt_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_mult_acc.sv
// Randomised self-checking bench for mult_acc against a queue-based
// model of group sums, buffer contents and the overflow flag.
module tb_mult_acc;

    localparam int K = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_vld;
    logic [11:0] in_data;
    logic        clr;
    logic        out_vld;
    logic        out_rdy;
    logic [13:0] out_sum;
    logic [1:0]  grp_idx;
    logic        ovf;

    int pass_cnt = 0;
    int total    = 0;

    int unsigned m_part;
    int unsigned m_n;
    int unsigned m_q[$];
    bit          m_ovf;

    mult_acc dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (in_vld),
        .in_data (in_data),
        .clr     (clr),
        .out_vld (out_vld),
        .out_rdy (out_rdy),
        .out_sum (out_sum),
        .grp_idx (grp_idx),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_part = 0;
        m_n    = 0;
        m_q.delete();
        m_ovf  = 1'b0;
    endtask

    task automatic model_edge(input bit v, input int unsigned d,
                              input bit r, input bit c);
        if (c) begin
            model_reset();
        end else begin
            if (r && m_q.size() > 0) void'(m_q.pop_front());
            if (v) begin
                m_part += d;
                m_n++;
                if (m_n == K) begin
                    if (m_q.size() < 2) m_q.push_back(m_part);
                    else m_ovf = 1'b1;
                    m_part = 0;
                    m_n    = 0;
                end
            end
        end
    endtask

    function automatic logic [13:0] exp_sum();
        return (m_q.size() > 0) ? 14'(m_q[0]) : 14'd0;
    endfunction

    // drive at negedge, model at posedge, return at next negedge
    task automatic step(input bit v, input int unsigned d,
                        input bit r, input bit c);
        in_vld  = v;
        in_data = 12'(d);
        out_rdy = r;
        clr     = c;
        @(posedge clk);
        model_edge(v, d, r, c);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        in_vld  = 1'b0;
        in_data = '0;
        clr     = 1'b0;
        out_rdy = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        total++;
        if ({out_vld, out_sum, grp_idx, ovf} !== 18'd0)
            $display("FAIL reset_outputs got %h want 0",
                     {out_vld, out_sum, grp_idx, ovf});
        else pass_cnt++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int unsigned p[4] = '{125, 160, 40, 105};
        logic [1:0]  idx_exp[4] = '{2'd1, 2'd2, 2'd3, 2'd0};
        total++;
        if (grp_idx !== 2'd0)
            $display("FAIL basic_idx0 got %0d want 0", grp_idx);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (out_vld !== 1'b0)
                $display("FAIL basic_early_vld at %0d got %b want 0",
                         i, out_vld);
            else pass_cnt++;
            step(1, p[i], 1, 0);
            total++;
            if (grp_idx !== idx_exp[i])
                $display("FAIL basic_idx%0d got %0d want %0d",
                         i + 1, grp_idx, idx_exp[i]);
            else pass_cnt++;
        end
        total++;
        if (out_vld !== 1'b1 || out_sum !== 14'd430)
            $display("FAIL basic_sum got vld=%b %0d want vld=1 430",
                     out_vld, out_sum);
        else pass_cnt++;
        step(0, 0, 1, 0);
        total++;
        if (out_vld !== 1'b0)
            $display("FAIL basic_vld_pulse got %b want 0", out_vld);
        else pass_cnt++;
    endtask

    task automatic test_gaps();
        for (int i = 0; i < 4; i++) begin
            step(1, (16 + i) * 7, 1, 0);
            step(0, 12'hfff, 1, 0);
            step(0, 12'h0aa, 1, 0);
            if (i < 3) begin
                total++;
                if (grp_idx !== 2'(i + 1))
                    $display("FAIL gaps_idx got %0d want %0d",
                             grp_idx, i + 1);
                else pass_cnt++;
            end
        end
        step(1, 3, 0, 0);
        step(0, 0, 1, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        total++;
        if (out_vld !== 1'b1 || out_sum !== 14'd3)
            $display("FAIL gaps_acc_hold got %0d want 3", out_sum);
        else pass_cnt++;
        step(0, 0, 1, 0);
        for (int i = 0; i < 4; i++) step(1, (16 + i) * 7, 0, 0);
        total++;
        if (out_vld !== 1'b1 || out_sum !== 14'd490)
            $display("FAIL gaps_sum got vld=%b %0d want 490",
                     out_vld, out_sum);
        else pass_cnt++;
        step(0, 0, 1, 0);
    endtask

    task automatic test_max();
        for (int i = 0; i < 4; i++) step(1, 3825, 1, 0);
        total++;
        if (out_vld !== 1'b1 || out_sum !== 14'd15300)
            $display("FAIL max_sum got vld=%b %0d want 15300",
                     out_vld, out_sum);
        else pass_cnt++;
        step(0, 0, 1, 0);
    endtask

    task automatic test_overflow();
        int unsigned p[4] = '{125, 160, 40, 105};
        for (int g = 0; g < 3; g++) begin
            for (int i = 0; i < 4; i++) step(1, p[i], 0, 0);
            if (g == 1) begin
                total++;
                if (ovf !== 1'b0 || out_vld !== 1'b1)
                    $display("FAIL ovf_two_groups got ovf=%b vld=%b want 0 1",
                             ovf, out_vld);
                else pass_cnt++;
            end
        end
        total++;
        if (ovf !== 1'b1 || out_sum !== 14'd430)
            $display("FAIL ovf_set got ovf=%b sum=%0d want 1 430",
                     ovf, out_sum);
        else pass_cnt++;
        step(0, 0, 1, 0);
        total++;
        if (out_vld !== 1'b1 || out_sum !== 14'd430)
            $display("FAIL ovf_second got vld=%b %0d want 1 430",
                     out_vld, out_sum);
        else pass_cnt++;
        step(0, 0, 1, 0);
        total++;
        if (out_vld !== 1'b0 || ovf !== 1'b1)
            $display("FAIL ovf_drain got vld=%b ovf=%b want 0 1",
                     out_vld, ovf);
        else pass_cnt++;
    endtask

    task automatic test_push_pop_full();
        int unsigned sa, sb, sc, d;
        step(0, 0, 0, 1);
        total++;
        if (ovf !== 1'b0)
            $display("FAIL ppf_clr_ovf got %b want 0", ovf);
        else pass_cnt++;
        sa = 0; sb = 0; sc = 0;
        for (int i = 0; i < 4; i++) begin
            d = $urandom_range(255) * $urandom_range(15);
            sa += d;
            step(1, d, 0, 0);
        end
        for (int i = 0; i < 4; i++) begin
            d = $urandom_range(255) * $urandom_range(15);
            sb += d;
            step(1, d, 0, 0);
        end
        for (int i = 0; i < 4; i++) begin
            d = $urandom_range(255) * $urandom_range(15);
            sc += d;
            step(1, d, (i == 3), 0);
        end
        total++;
        if (out_sum !== 14'(sb) || ovf !== 1'b0)
            $display("FAIL ppf_head got %0d ovf=%b want %0d 0",
                     out_sum, ovf, sb);
        else pass_cnt++;
        step(0, 0, 1, 0);
        total++;
        if (out_vld !== 1'b1 || out_sum !== 14'(sc))
            $display("FAIL ppf_tail got %0d want %0d", out_sum, sc);
        else pass_cnt++;
        step(0, 0, 1, 0);
        total++;
        if (out_vld !== 1'b0 || ovf !== 1'b0)
            $display("FAIL ppf_empty got vld=%b ovf=%b want 0 0",
                     out_vld, ovf);
        else pass_cnt++;
        if (sa == 0) $display("note: group A summed to zero");
    endtask

    task automatic test_clr();
        for (int i = 0; i < 12; i++) step(1, 77, 0, 0);
        step(1, 9, 0, 0);
        step(1, 9, 0, 0);
        total++;
        if (ovf !== 1'b1 || grp_idx !== 2'd2)
            $display("FAIL clr_setup got ovf=%b idx=%0d want 1 2",
                     ovf, grp_idx);
        else pass_cnt++;
        step(1, 50, 1, 1);
        total++;
        if ({out_vld, grp_idx, ovf} !== 4'd0 || out_sum !== 14'd0)
            $display("FAIL clr_state got vld=%b idx=%0d ovf=%b sum=%0d",
                     out_vld, grp_idx, ovf, out_sum);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) step(1, 1, 1, 0);
        total++;
        if (out_vld !== 1'b1 || out_sum !== 14'd4)
            $display("FAIL clr_regroup got %0d want 4", out_sum);
        else pass_cnt++;
        step(0, 0, 1, 0);
    endtask

    task automatic test_async_reset();
        int unsigned s;
        step(1, 200, 0, 0);
        step(1, 300, 0, 0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        total++;
        if ({out_vld, out_sum, grp_idx, ovf} !== 18'd0)
            $display("FAIL async_reset got %h want 0",
                     {out_vld, out_sum, grp_idx, ovf});
        else pass_cnt++;
        in_vld = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        s = 0;
        for (int i = 0; i < 4; i++) begin
            in_data = 12'($urandom_range(255) * $urandom_range(15));
            s += in_data;
            step(1, in_data, 0, 0);
        end
        total++;
        if (out_vld !== 1'b1 || out_sum !== 14'(s))
            $display("FAIL async_regroup got %0d want %0d", out_sum, s);
        else pass_cnt++;
        step(0, 0, 1, 0);
    endtask

    task automatic test_random();
        bit          v, r, c;
        int unsigned d;
        for (int n = 0; n < 400; n++) begin
            v = ($urandom_range(3) != 0);
            r = ($urandom_range(2) == 0);
            c = ($urandom_range(59) == 0);
            d = $urandom_range(255) * $urandom_range(15);
            step(v, d, r, c);
            total++;
            if (out_vld !== (m_q.size() > 0))
                $display("FAIL rand_vld cyc %0d got %b want %b",
                         n, out_vld, m_q.size() > 0);
            else pass_cnt++;
            total++;
            if (out_sum !== exp_sum())
                $display("FAIL rand_sum cyc %0d got %0d want %0d",
                         n, out_sum, exp_sum());
            else pass_cnt++;
            total++;
            if (grp_idx !== 2'(m_n))
                $display("FAIL rand_idx cyc %0d got %0d want %0d",
                         n, grp_idx, m_n);
            else pass_cnt++;
            total++;
            if (ovf !== m_ovf)
                $display("FAIL rand_ovf cyc %0d got %b want %b",
                         n, ovf, m_ovf);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_max();
        test_overflow();
        test_push_pop_full();
        test_clr();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
